axi_master_engine: RTL and testbench
====================================

Name: axi_master_engine

Overview:
- Single-outstanding AXI-style initiator that issues read and write bursts to the team's 16-bit, 5-bit-address AXI register slave.
- Accepts one command at a time from a local controller (test sequencer or bridge front end).
- Streams write data in and read data out, then reports completion and error status.
- Drives the AR/AW/W/B/R channels with the same port names as the slave side, so the two connect wire-for-wire.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent waiting on any single slave handshake before abort (1..2^TO_W-1)
TO_W, 8, width of timeout counter

Ports:
clk  input  1  clock, all logic on rising edge
res_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE
cmd_write  input  1  1=write, 0=read
cmd_addr  input  5  start address
cmd_len  input  4  beats minus one (0..15)
cmd_incr  input  1  1=INCR burst (2'b01), 0=FIXED (2'b00)
wr_data_in  input  16  write beat data
wr_valid_in  input  1  write beat available
wr_ready_out  output  1  write beat consumed this cycle
rd_data_out  output  16  read beat data
rd_valid_out  output  1  read beat valid
rd_last_out  output  1  final read beat
rd_ready_in  input  1  downstream accepts read beat
done  output  1  one-cycle completion pulse
err  output  1  error status of the last transaction, valid with done
busy  output  1  not IDLE
arvalid, araddr[4:0], arlen[3:0], arsize[2:0], arburst[1:0]  output  AR channel
arready  input  1
awvalid, awaddr[4:0], awlen[3:0], awsize[2:0], awburst[1:0]  output  AW channel
awready  input  1
wvalid, wdata[15:0], wlast  output  W channel
wready  input  1
bvalid  input  1;  bresp  input  2;  bready  output  1
rvalid  input  1;  rdata  input  16;  rresp  input  2;  rlast  input  1;  rready  output  1

Behaviour:
- Reset (async, res_n low):
  - State returns to IDLE.
  - All valid/ready/last outputs, done, err, busy and the beat counter go to 0.
  - Address/len outputs go to 0; arsize/awsize go to 3'b001.
  - Reset mid-burst abandons the transaction immediately; no done pulse.
- States: IDLE, AR, RDAT, AW, WDAT, BRESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr, len, burst and write flag; load beat counter with cmd_len; clear the err accumulator.
  - Go to AW if write, AR if read. arvalid/awvalid rise the cycle after acceptance.
- AR / AW:
  - Hold valid and all channel fields stable until ready is sampled high.
  - Then go to RDAT / WDAT.
  - arsize/awsize are always 3'b001; arlen/awlen = latched len.
- RDAT:
  - rready = rd_ready_in (combinational); rd_data_out = rdata; rd_valid_out = rvalid.
  - rready must be driven even before rvalid rises.
  - A beat completes when rvalid && rready. On each beat: decrement the counter; OR rresp!=2'b00 into err.
  - rd_last_out = rvalid && counter==0.
  - Protocol error (sets err):
    - rlast high on a beat with counter!=0, or
    - rlast low on the beat with counter==0.
  - The burst always ends on the counter==0 beat, regardless of rlast. Then go to IDLE with done=1 for one cycle.
- WDAT:
  - wvalid = wr_valid_in; wdata = wr_data_in; wlast = (counter==0).
  - Beat completes when wvalid && wready; wr_ready_out = wready && wr_valid_in.
  - wvalid may drop between beats only when wr_valid_in is low; once asserted it is held until wready.
  - After the counter==0 beat, go to BRESP.
- BRESP:
  - bready=1.
  - On bvalid: OR bresp!=2'b00 into err, pulse done, go to IDLE.
- Timeout:
  - Counter resets on every state change and on every completed beat; it increments otherwise in AR, AW, RDAT, WDAT, BRESP.
  - While in RDAT/WDAT, the counter is also held while rd_ready_in or wr_valid_in is low; local stalls never time out.
  - Reaching TIMEOUT_CYCLES: deassert all channel valid/ready outputs, set err, pulse done, go to IDLE.
- Address stepping is left to the slave: the master presents only the start address.
- A command presented while busy is not accepted (cmd_ready=0), and no command is lost.
- done and the next cmd_ready are coincident: a new command can be accepted the cycle after done.

Test Plan:
1. Write addr 5, len 0, data 16'hA5A5, slave OKAY.
   - Required: awvalid one cycle after accept; awaddr=5, awlen=0, awburst=01; single W beat with wlast=1.
   - Then bready; done=1, err=0.
   - Read-back of addr 5 returns 16'hA5A5.
2. INCR read addr 0, len 1 from reset-state slave.
   - Required: rd_data_out 16'hFFFF then 16'h1111; rd_last_out only on the second beat; done, err=0.
3. FIXED write addr 2, len 3, with wr_valid_in low for 2 cycles between beats 1 and 2.
   - Required: exactly 4 W beats; wlast only on the 4th; no timeout.
4. Read with rd_ready_in low for 5 cycles mid-burst.
   - Required: rready low during the stall, rd_data_out unchanged, no beat lost, no timeout.
5. Error paths.
   - Slave model returns bresp=2'b10: done with err=1.
   - Slave model asserts rlast on beat 1 of a 3-beat read: err=1, all 3 beats still consumed.
6. Timeout and reset.
   - arready held low: done with err=1 after TIMEOUT_CYCLES cycles, arvalid=0 afterwards.
   - res_n pulsed low mid write burst: all outputs 0 immediately, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_master_engine.sv
// Single-outstanding AXI-style burst initiator for the 16-bit, 5-bit-address register slave.
// Accepts one local command, runs the AR/R or AW/W/B exchange, then pulses done with error status.
module axi_master_engine #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic        cmd_incr,
    input  logic [15:0] wr_data_in,
    input  logic        wr_valid_in,
    output logic        wr_ready_out,
    output logic [15:0] rd_data_out,
    output logic        rd_valid_out,
    output logic        rd_last_out,
    input  logic        rd_ready_in,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        arvalid,
    output logic [4:0]  araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        arready,
    output logic        awvalid,
    output logic [4:0]  awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    input  logic        awready,
    output logic        wvalid,
    output logic [15:0] wdata,
    output logic        wlast,
    input  logic        wready,
    input  logic        bvalid,
    input  logic [1:0]  bresp,
    output logic        bready,
    input  logic        rvalid,
    input  logic [15:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic        rready
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_RDAT  = 3'd2,
        ST_AW    = 3'd3,
        ST_WDAT  = 3'd4,
        ST_BRESP = 3'd5
    } state_t;

    state_t          state_r;
    logic [4:0]      addr_r;
    logic [3:0]      len_r;
    logic [3:0]      cnt_r;
    logic [1:0]      burst_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            arvalid_r;
    logic            awvalid_r;
    logic            done_r;
    logic            err_r;
    logic            err_acc_r;
    logic            cmd_ready_r;

    logic            last_beat_s;
    logic            to_hit_s;
    logic            r_beat_s;
    logic            w_beat_s;
    logic            r_err_s;
    logic            stall_s;
    logic            progress_s;

    assign last_beat_s = (cnt_r == 4'd0);
    assign to_hit_s    = (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Per-cycle beat, local-stall, progress and read-beat error qualifiers
    always_comb begin
        r_beat_s   = 1'b0;
        w_beat_s   = 1'b0;
        r_err_s    = 1'b0;
        stall_s    = 1'b0;
        progress_s = 1'b0;
        case (state_r)
            ST_AR:    progress_s = arready;
            ST_AW:    progress_s = awready;
            ST_BRESP: progress_s = bvalid;
            ST_RDAT: begin
                r_beat_s   = rvalid && rd_ready_in;
                stall_s    = !rd_ready_in;
                progress_s = rvalid && rd_ready_in;
                // rlast must coincide exactly with the counter==0 beat
                r_err_s    = (rresp != 2'b00) || (rlast != last_beat_s);
            end
            ST_WDAT: begin
                w_beat_s   = wr_valid_in && wready;
                stall_s    = !wr_valid_in;
                progress_s = wr_valid_in && wready;
            end
            default: begin
                progress_s = 1'b0;
            end
        endcase
    end

    // Main FSM: command capture, channel sequencing, error accumulation and timeout
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= 5'd0;
            len_r       <= 4'd0;
            cnt_r       <= 4'd0;
            burst_r     <= 2'b00;
            to_cnt_r    <= '0;
            arvalid_r   <= 1'b0;
            awvalid_r   <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_acc_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cmd_ready_r <= 1'b1;
                    to_cnt_r    <= '0;
                    if (cmd_valid && cmd_ready_r) begin
                        addr_r      <= cmd_addr;
                        len_r       <= cmd_len;
                        cnt_r       <= cmd_len;
                        burst_r     <= cmd_incr ? 2'b01 : 2'b00;
                        err_acc_r   <= 1'b0;
                        cmd_ready_r <= 1'b0;
                        if (cmd_write) begin
                            awvalid_r <= 1'b1;
                            state_r   <= ST_AW;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid_r <= 1'b0;
                        state_r   <= ST_RDAT;
                    end
                end
                ST_AW: begin
                    if (awready) begin
                        awvalid_r <= 1'b0;
                        state_r   <= ST_WDAT;
                    end
                end
                ST_RDAT: begin
                    if (r_beat_s) begin
                        if (last_beat_s) begin
                            err_r       <= err_acc_r | r_err_s;
                            done_r      <= 1'b1;
                            cmd_ready_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            cnt_r     <= cnt_r - 4'd1;
                            err_acc_r <= err_acc_r | r_err_s;
                        end
                    end
                end
                ST_WDAT: begin
                    if (w_beat_s) begin
                        if (last_beat_s) begin
                            state_r <= ST_BRESP;
                        end else begin
                            cnt_r <= cnt_r - 4'd1;
                        end
                    end
                end
                ST_BRESP: begin
                    if (bvalid) begin
                        err_r       <= err_acc_r | (bresp != 2'b00);
                        done_r      <= 1'b1;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // Watchdog: a stuck slave handshake aborts; local stalls only freeze the count
            if (state_r != ST_IDLE) begin
                if (progress_s) begin
                    to_cnt_r <= '0;
                end else if (stall_s) begin
                    to_cnt_r <= to_cnt_r;
                end else if (to_hit_s) begin
                    to_cnt_r    <= '0;
                    arvalid_r   <= 1'b0;
                    awvalid_r   <= 1'b0;
                    err_r       <= 1'b1;
                    done_r      <= 1'b1;
                    cmd_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end else begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                end
            end
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign busy         = (state_r != ST_IDLE);
    assign done         = done_r;
    assign err          = err_r;

    assign arvalid      = arvalid_r;
    assign araddr       = addr_r;
    assign arlen        = len_r;
    assign arsize       = 3'b001;
    assign arburst      = burst_r;
    assign awvalid      = awvalid_r;
    assign awaddr       = addr_r;
    assign awlen        = len_r;
    assign awsize       = 3'b001;
    assign awburst      = burst_r;

    assign wvalid       = (state_r == ST_WDAT) && wr_valid_in;
    assign wdata        = wr_data_in;
    assign wlast        = (state_r == ST_WDAT) && last_beat_s;
    assign wr_ready_out = (state_r == ST_WDAT) && wready && wr_valid_in;
    assign bready       = (state_r == ST_BRESP);

    assign rready       = (state_r == ST_RDAT) && rd_ready_in;
    assign rd_valid_out = (state_r == ST_RDAT) && rvalid;
    assign rd_data_out  = rdata;
    assign rd_last_out  = (state_r == ST_RDAT) && rvalid && last_beat_s;

endmodule

// File: tb/tb_axi_master_engine.sv
// Scoreboard bench for axi_master_engine with a behavioural register-slave model.
// Stimulus pushes expected channel/beat/completion records; a negedge monitor pops and compares.
module tb_axi_master_engine;

    localparam int TB_TO = 4;

    logic        clk = 1'b0;
    logic        res_n;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_incr;
    logic [4:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic [15:0] wr_data_in, rd_data_out;
    logic        wr_valid_in, wr_ready_out, rd_valid_out, rd_last_out, rd_ready_in;
    logic        done, err, busy;
    logic        arvalid, arready, awvalid, awready;
    logic [4:0]  araddr, awaddr;
    logic [3:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;
    logic        wvalid, wlast, wready, bvalid, bready, rvalid, rlast, rready;
    logic [15:0] wdata, rdata;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axi_master_engine #(.TIMEOUT_CYCLES(TB_TO), .TO_W(8)) dut (
        .clk(clk), .res_n(res_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_incr(cmd_incr),
        .wr_data_in(wr_data_in), .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out),
        .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .rd_last_out(rd_last_out),
        .rd_ready_in(rd_ready_in), .done(done), .err(err), .busy(busy),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arready(arready),
        .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready)
    );

    // ---------------- slave model ----------------
    logic [15:0] mem [0:31];
    logic        r_act, w_act, b_pend, r_incr, w_incr;
    logic [4:0]  r_addr, w_addr;
    logic [3:0]  r_len, r_idx, w_len, w_idx;
    logic        ar_block = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    int          rlast_flip = -1;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = (i < 16) ? 16'(i) * 16'h1111 : 16'h0000;
        mem[0] = 16'hFFFF;
    end

    assign arready = !ar_block && !r_act;
    assign rvalid  = r_act;
    assign rdata   = mem[r_addr];
    assign rresp   = rresp_cfg;
    assign rlast   = r_act && ((r_idx == r_len) ^ (int'(r_idx) == rlast_flip));
    assign awready = !w_act && !b_pend;
    assign wready  = w_act;
    assign bvalid  = b_pend;
    assign bresp   = bresp_cfg;

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_act <= 1'b0; w_act <= 1'b0; b_pend <= 1'b0; r_incr <= 1'b0; w_incr <= 1'b0;
            r_addr <= 5'd0; w_addr <= 5'd0; r_len <= 4'd0; r_idx <= 4'd0;
            w_len <= 4'd0; w_idx <= 4'd0;
        end else begin
            if (arvalid && arready) begin
                r_act <= 1'b1; r_addr <= araddr; r_len <= arlen; r_idx <= 4'd0;
                r_incr <= (arburst == 2'b01);
            end else if (rvalid && rready) begin
                r_idx <= r_idx + 4'd1;
                if (r_incr) r_addr <= r_addr + 5'd1;
                if (r_idx == r_len) r_act <= 1'b0;
            end
            if (awvalid && awready) begin
                w_act <= 1'b1; w_addr <= awaddr; w_len <= awlen; w_idx <= 4'd0;
                w_incr <= (awburst == 2'b01);
            end else if (wvalid && wready) begin
                mem[w_addr] <= wdata;
                w_idx <= w_idx + 4'd1;
                if (w_incr) w_addr <= w_addr + 5'd1;
                if (w_idx == w_len) begin
                    w_act  <= 1'b0;
                    b_pend <= 1'b1;
                end
            end
            if (bvalid && bready) b_pend <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad = 0;
    logic [11:0] exp_ax[$];
    logic [16:0] exp_w[$];
    logic [16:0] exp_r[$];
    logic        exp_done[$];
    logic [15:0] wr_src[$];
    int          ar_hi_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every DUT handshake/presentation is checked against the queued expectation
    initial begin
        logic [16:0] e17;
        logic [11:0] e12;
        forever begin
            @(negedge clk);
            if (res_n) begin
                if (arvalid) ar_hi_cnt++;
                if (arvalid && arready) begin
                    if (exp_ax.size() == 0) chk("ar_unexpected", 0, 1);
                    else begin
                        e12 = exp_ax.pop_front();
                        chk("ar_fields", {1'b0, araddr, arlen, arburst}, e12);
                        chk("arsize", arsize, 3'b001);
                    end
                end
                if (awvalid && awready) begin
                    if (exp_ax.size() == 0) chk("aw_unexpected", 0, 1);
                    else begin
                        e12 = exp_ax.pop_front();
                        chk("aw_fields", {1'b1, awaddr, awlen, awburst}, e12);
                        chk("awsize", awsize, 3'b001);
                    end
                end
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) chk("w_unexpected", 0, 1);
                    else begin
                        e17 = exp_w.pop_front();
                        chk("w_beat", {wlast, wdata}, e17);
                    end
                end
                if (rd_valid_out && rd_ready_in) begin
                    chk("rready", rready, 1);
                    if (exp_r.size() == 0) chk("r_unexpected", 0, 1);
                    else begin
                        e17 = exp_r.pop_front();
                        chk("r_beat", {rd_last_out, rd_data_out}, e17);
                    end
                end
                if (rd_valid_out && !rd_ready_in && exp_r.size() != 0) begin
                    e17 = exp_r[0];
                    chk("stall_rready", rready, 0);
                    chk("stall_rdata", rd_data_out, e17[15:0]);
                end
                if (bvalid) chk("bready", bready, 1);
                if (done) begin
                    if (exp_done.size() == 0) chk("done_unexpected", 0, 1);
                    else chk("done_err", err, exp_done.pop_front());
                end
            end
        end
    end

    // ---------------- local-side drivers ----------------
    int wr_beats = 0, wr_gap_after = -1, wr_gap_len = 0, gap_left = 0;
    int rd_beats = 0, rd_stall_after = -1, rd_stall_len = 0, stall_left = 0;

    // Write source and read sink: inputs change only just after the rising edge
    initial begin
        bit w_hs, r_hs;
        wr_valid_in = 1'b0; wr_data_in = 16'h0000; rd_ready_in = 1'b1;
        forever begin
            @(negedge clk);
            w_hs = wr_valid_in && wr_ready_out;
            r_hs = rd_valid_out && rd_ready_in;
            @(posedge clk);
            #1;
            if (w_hs && wr_src.size() != 0) begin
                void'(wr_src.pop_front());
                wr_beats++;
                if (wr_beats == wr_gap_after) gap_left = wr_gap_len;
            end
            if (r_hs) begin
                rd_beats++;
                if (rd_beats == rd_stall_after) stall_left = rd_stall_len;
            end
            if (gap_left > 0) begin
                wr_valid_in = 1'b0;
                gap_left--;
            end else begin
                wr_valid_in = (wr_src.size() != 0);
                if (wr_src.size() != 0) wr_data_in = wr_src[0];
            end
            if (stall_left > 0) begin
                rd_ready_in = 1'b0;
                stall_left--;
            end else begin
                rd_ready_in = 1'b1;
            end
        end
    end

    task automatic push_w(input logic [15:0] d, input logic l);
        exp_w.push_back({l, d});
        wr_src.push_back(d);
    endtask

    task automatic push_r(input logic [15:0] d, input logic l);
        exp_r.push_back({l, d});
    endtask

    task automatic issue(input logic wr, input logic [4:0] a, input logic [3:0] l,
                         input logic inc, input logic exp_err, input bit ax_ok);
        int n = 0;
        if (ax_ok) exp_ax.push_back({wr, a, l, inc ? 2'b01 : 2'b00});
        exp_done.push_back(exp_err);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_incr = inc;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("ax_valid_next", wr ? awvalid : arvalid, 1);
        chk("busy_cmdready", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_done.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_pending"}, exp_done.size(), 0);
        chk({name, "_beats_left"}, exp_r.size() + exp_w.size() + exp_ax.size(), 0);
        exp_done.delete(); exp_r.delete(); exp_w.delete(); exp_ax.delete();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        res_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 5'd0;
        cmd_len = 4'd0; cmd_incr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", {arvalid, awvalid, wvalid, wlast, wr_ready_out, rready, bready,
                          done, err, busy, cmd_ready, rd_valid_out, rd_last_out}, 13'd0);
        chk("reset_fields", {araddr, arlen, arburst, arsize, awaddr, awlen, awburst, awsize},
            {5'd0, 4'd0, 2'b00, 3'b001, 5'd0, 4'd0, 2'b00, 3'b001});
        res_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // 1: single-beat write, then read back
        push_w(16'hA5A5, 1'b1);
        issue(1'b1, 5'd5, 4'd0, 1'b1, 1'b0, 1'b1);
        wait_idle("t1_write");
        push_r(16'hA5A5, 1'b1);
        issue(1'b0, 5'd5, 4'd0, 1'b1, 1'b0, 1'b1);
        wait_idle("t1_readback");

        // 2: INCR read of reset-state contents
        push_r(16'hFFFF, 1'b0);
        push_r(16'h1111, 1'b1);
        issue(1'b0, 5'd0, 4'd1, 1'b1, 1'b0, 1'b1);
        wait_idle("t2_read");

        // 3: FIXED write with a 2-cycle source gap, final value lands at addr 2
        wr_beats = 0; wr_gap_after = 2; wr_gap_len = 2;
        push_w(16'h0001, 1'b0); push_w(16'h0002, 1'b0);
        push_w(16'h0003, 1'b0); push_w(16'h0004, 1'b1);
        issue(1'b1, 5'd2, 4'd3, 1'b0, 1'b0, 1'b1);
        wait_idle("t3_write_gap");
        wr_gap_after = -1;
        push_r(16'h0004, 1'b1);
        issue(1'b0, 5'd2, 4'd0, 1'b0, 1'b0, 1'b1);
        wait_idle("t3_readback");

        // 4: read with a 5-cycle downstream stall after the first beat
        rd_beats = 0; rd_stall_after = 1; rd_stall_len = 5;
        push_r(16'h8888, 1'b0); push_r(16'h9999, 1'b0);
        push_r(16'hAAAA, 1'b0); push_r(16'hBBBB, 1'b1);
        issue(1'b0, 5'd8, 4'd3, 1'b1, 1'b0, 1'b1);
        wait_idle("t4_read_stall");
        rd_stall_after = -1;

        // 5: error responses and rlast protocol errors
        bresp_cfg = 2'b10;
        push_w(16'h1234, 1'b1);
        issue(1'b1, 5'd3, 4'd0, 1'b1, 1'b1, 1'b1);
        wait_idle("t5_bresp");
        bresp_cfg = 2'b00;
        rlast_flip = 1;
        push_r(16'hCCCC, 1'b0); push_r(16'hDDDD, 1'b0); push_r(16'hEEEE, 1'b1);
        issue(1'b0, 5'd12, 4'd2, 1'b1, 1'b1, 1'b1);
        wait_idle("t5_early_rlast");
        rlast_flip = 0;
        push_r(16'h7777, 1'b1);
        issue(1'b0, 5'd7, 4'd0, 1'b1, 1'b1, 1'b1);
        wait_idle("t5_missing_rlast");
        rlast_flip = -1;
        rresp_cfg = 2'b10;
        push_r(16'h1111, 1'b1);
        issue(1'b0, 5'd1, 4'd0, 1'b1, 1'b1, 1'b1);
        wait_idle("t5_rresp");
        rresp_cfg = 2'b00;

        // 6a: AR never accepted -> timeout abort
        ar_block = 1'b1;
        ar_hi_cnt = 0;
        issue(1'b0, 5'd0, 4'd0, 1'b1, 1'b1, 1'b0);
        wait_idle("t6_timeout");
        @(negedge clk);
        chk("timeout_cycles", ar_hi_cnt, TB_TO);
        chk("arvalid_after_timeout", arvalid, 0);
        ar_block = 1'b0;
        @(posedge clk);
        #1;

        // 6b: reset mid write burst abandons the transaction
        wr_beats = 0;
        push_w(16'h0101, 1'b0); push_w(16'h0202, 1'b0);
        push_w(16'h0303, 1'b0); push_w(16'h0404, 1'b1);
        issue(1'b1, 5'd20, 4'd3, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (wr_beats < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_two_beats", wr_beats, 2);
        #2 res_n = 1'b0;
        #1;
        chk("midburst_reset_outputs", {arvalid, awvalid, wvalid, wlast, wr_ready_out, rready,
                                       bready, done, busy, cmd_ready, rd_valid_out}, 11'd0);
        exp_done.delete(); exp_r.delete(); exp_w.delete(); exp_ax.delete(); wr_src.delete();
        repeat (2) @(posedge clk);
        #1 res_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("cmd_ready_after_release", {cmd_ready, busy}, 2'b10);

        // Engine usable after reset; slave contents survive
        push_r(16'hA5A5, 1'b1);
        issue(1'b0, 5'd5, 4'd0, 1'b1, 1'b0, 1'b1);
        wait_idle("t6_post_reset_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
